// File: rtl/draw_control.sv
// Control sequencer for the drawing datapath: background fill, car draw,
// frame-synchronous erase/move/redraw, with car position and frame timer.
module draw_control #(
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter int unsigned CAR_W       = 8,
  parameter int unsigned CAR_H       = 12,
  parameter int unsigned STEP        = 2,
  parameter int unsigned FRAME_TICKS = 833333
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       left_i,
  input  logic       right_i,
  output logic       draw_bg_o,
  output logic       draw_car_o,
  output logic       erase_o,
  output logic       plot_o,
  output logic       inc_o,
  output logic       done_bg_o,
  output logic       done_car_o,
  output logic       done_erase_o,
  output logic [7:0] xpoint_o,
  output logic [7:0] ypoint_o,
  output logic       busy_o
);

  localparam int unsigned FW     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [7:0]  CAR_X0 = 8'((SCREEN_W - CAR_W) / 2);
  localparam logic [7:0]  CAR_Y  = 8'(SCREEN_H - CAR_H - 4);
  localparam logic [7:0]  X_MAX  = 8'(SCREEN_W - CAR_W);
  localparam logic [7:0]  STEP_W = 8'(STEP);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAW_BG, S_DRAW_CAR, S_WAIT, S_ERASE, S_MOVE
  } state_e;

  function automatic logic [7:0] width_of(input state_e s);
    return (s == S_DRAW_BG) ? 8'(SCREEN_W) : 8'(CAR_W);
  endfunction

  function automatic logic [7:0] height_of(input state_e s);
    return (s == S_DRAW_BG) ? 8'(SCREEN_H) : 8'(CAR_H);
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      sx_q, sx_d, sy_q, sy_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [7:0]      car_x_q, car_x_d, next_x_q, next_x_d;
  logic            draw_bg_q, draw_bg_d, draw_car_q, draw_car_d, erase_q, erase_d;
  logic            plot_q, plot_d, inc_q, inc_d, busy_q, busy_d;
  logic            done_bg_q, done_bg_d, done_car_q, done_car_d, done_erase_q, done_erase_d;
  logic [7:0]      xpoint_q, xpoint_d, ypoint_q, ypoint_d;

  logic            tick;
  logic [7:0]      cand_x, cur_w, cur_h, nxt_w, nxt_h;
  logic [8:0]      sum_x;
  logic            last_col, last_row, sweep_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      sx_q         <= '0;
      sy_q         <= '0;
      frame_q      <= '0;
      car_x_q      <= CAR_X0;
      next_x_q     <= CAR_X0;
      draw_bg_q    <= 1'b0;
      draw_car_q   <= 1'b0;
      erase_q      <= 1'b0;
      plot_q       <= 1'b0;
      inc_q        <= 1'b0;
      done_bg_q    <= 1'b0;
      done_car_q   <= 1'b0;
      done_erase_q <= 1'b0;
      xpoint_q     <= '0;
      ypoint_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      frame_q      <= frame_d;
      car_x_q      <= car_x_d;
      next_x_q     <= next_x_d;
      draw_bg_q    <= draw_bg_d;
      draw_car_q   <= draw_car_d;
      erase_q      <= erase_d;
      plot_q       <= plot_d;
      inc_q        <= inc_d;
      done_bg_q    <= done_bg_d;
      done_car_q   <= done_car_d;
      done_erase_q <= done_erase_d;
      xpoint_q     <= xpoint_d;
      ypoint_q     <= ypoint_d;
      busy_q       <= busy_d;
    end
  end

  // Next state first; outputs are then decoded from the next state so the
  // registered strobes line up with the state they describe.
  always_comb begin
    state_d  = state_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    car_x_d  = car_x_q;
    next_x_d = next_x_q;

    tick    = (frame_q == FW'(FRAME_TICKS - 1));
    frame_d = tick ? '0 : frame_q + FW'(1);

    sum_x = {1'b0, car_x_q} + 9'(STEP);
    if (left_i) begin
      cand_x = (car_x_q >= STEP_W) ? car_x_q - STEP_W : '0;
    end else begin
      cand_x = (sum_x > {1'b0, X_MAX}) ? X_MAX : sum_x[7:0];
    end

    cur_w    = width_of(state_q);
    cur_h    = height_of(state_q);
    last_col = (sx_q == cur_w - 8'd1);
    last_row = (sy_q == cur_h - 8'd1);

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_DRAW_BG;
      end
      S_DRAW_BG, S_DRAW_CAR, S_ERASE: begin
        if (last_col && last_row) begin
          sx_d = '0;
          sy_d = '0;
          case (state_q)
            S_DRAW_BG:  state_d = S_DRAW_CAR;
            S_DRAW_CAR: state_d = S_WAIT;
            default:    state_d = S_MOVE;
          endcase
        end else if (last_col) begin
          sx_d = '0;
          sy_d = sy_q + 8'd1;
        end else begin
          sx_d = sx_q + 8'd1;
        end
      end
      S_WAIT: begin
        if (tick && (left_i ^ right_i) && (cand_x != car_x_q)) begin
          next_x_d = cand_x;
          state_d  = S_ERASE;
        end
      end
      S_MOVE: begin
        car_x_d = next_x_q;
        state_d = S_DRAW_CAR;
      end
      default: state_d = S_IDLE;
    endcase

    nxt_w        = width_of(state_d);
    nxt_h        = height_of(state_d);
    sweep_d      = state_d inside {S_DRAW_BG, S_DRAW_CAR, S_ERASE};
    draw_bg_d    = (state_d == S_DRAW_BG);
    draw_car_d   = (state_d == S_DRAW_CAR);
    erase_d      = (state_d == S_ERASE);
    plot_d       = sweep_d;
    inc_d        = sweep_d && (sx_d == nxt_w - 8'd1);
    done_bg_d    = draw_bg_d  && inc_d && (sy_d == nxt_h - 8'd1);
    done_car_d   = draw_car_d && inc_d && (sy_d == nxt_h - 8'd1);
    done_erase_d = erase_d    && inc_d && (sy_d == nxt_h - 8'd1);
    busy_d       = !(state_d inside {S_IDLE, S_WAIT});

    xpoint_d = xpoint_q;
    ypoint_d = ypoint_q;
    if (draw_bg_d) begin
      xpoint_d = '0;
      ypoint_d = '0;
    end else if (draw_car_d || erase_d) begin
      xpoint_d = car_x_d;
      ypoint_d = CAR_Y;
    end
  end

  assign draw_bg_o    = draw_bg_q;
  assign draw_car_o   = draw_car_q;
  assign erase_o      = erase_q;
  assign plot_o       = plot_q;
  assign inc_o        = inc_q;
  assign done_bg_o    = done_bg_q;
  assign done_car_o   = done_car_q;
  assign done_erase_o = done_erase_q;
  assign xpoint_o     = xpoint_q;
  assign ypoint_o     = ypoint_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_draw_control.sv
// Scoreboard bench for draw_control: a transaction-level model predicts each
// sweep (kind, origin, first cycle); a monitor reconstructs sweeps from outputs.
module tb_draw_control;

  localparam int SW = 160, SH = 120, CW = 8, CH = 12, STEP = 2, FT = 300;
  localparam int CAR_Y = SH - CH - 4;
  localparam int X0 = (SW - CW) / 2;
  localparam int X_MAX = SW - CW;
  localparam int BG_LEN = SW * SH;
  localparam int CAR_LEN = CW * CH;

  typedef struct {
    int kind;  // 0 background, 1 car, 2 erase
    int x;
    int y;
    int first;
  } sweep_t;

  logic clk = 1'b0;
  logic reset, start, left, right;
  logic draw_bg, draw_car, erase, plot, inc, done_bg, done_car, done_erase, busy;
  logic [7:0] xpoint, ypoint;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  sweep_t exp_q[$];
  bit     started = 0;
  int     mcx = X0;
  int     busy_from = 0, busy_until = 0;
  int     last_move = 0;
  bit     tick_eval = 0;

  draw_control #(.FRAME_TICKS(FT)) u_dut (
    .clock_i(clk), .reset_i(reset), .start_i(start), .left_i(left), .right_i(right),
    .draw_bg_o(draw_bg), .draw_car_o(draw_car), .erase_o(erase), .plot_o(plot),
    .inc_o(inc), .done_bg_o(done_bg), .done_car_o(done_car), .done_erase_o(done_erase),
    .xpoint_o(xpoint), .ypoint_o(ypoint), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Cycle index since the last reset edge; equals the DUT frame count mod FT.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus plus the reference model's view of that cycle.
  task automatic step(input bit rs, input bit l, input bit r, input bit st);
    int nx;
    @(negedge clk);
    reset = rs; left = l; right = r; start = st;
    tick_eval = 0;
    if (rs) begin
      exp_q.delete();
      started = 0; mcx = X0; busy_from = 0; busy_until = 0;
    end else if (!started) begin
      if (st) begin
        started = 1;
        exp_q.push_back('{0, 0, 0, cyc + 1});
        exp_q.push_back('{1, mcx, CAR_Y, cyc + 1 + BG_LEN});
        busy_from = cyc + 1;
        busy_until = cyc + 1 + BG_LEN + CAR_LEN;
      end
    end else if ((cyc % FT) == FT - 1 && cyc >= busy_until) begin
      tick_eval = 1;
      if (l ^ r) begin
        if (l) nx = (mcx >= STEP) ? mcx - STEP : 0;
        else   nx = (mcx + STEP > X_MAX) ? X_MAX : mcx + STEP;
        if (nx != mcx) begin
          exp_q.push_back('{2, mcx, CAR_Y, cyc + 1});
          exp_q.push_back('{1, nx, CAR_Y, cyc + 2 + CAR_LEN});
          mcx = nx;
          last_move = cyc;
          busy_from = cyc + 1;
          busy_until = cyc + 2 + 2 * CAR_LEN;
        end
      end
    end
  endtask

  task automatic run_frame(input bit l, input bit r);
    int n = 0;
    do begin
      step(0, l, r, 0);
      n++;
    end while (!tick_eval && n < 1000);
    if (!tick_eval) check("frame_timeout", n, -1);
  endtask

  task automatic wait_model_idle();
    int n = 0;
    while (cyc < busy_until && n < 25000) begin
      step(0, 0, 0, 0);
      n++;
    end
  endtask

  // Monitor: rebuilds each sweep from the output stream and scores it.
  initial begin
    bit in_sweep = 0;
    int kind, ckind, cx, cy, cfirst, clen, cinc, w, h;
    sweep_t e;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        check("reset_outputs", int'({draw_bg, draw_car, erase, plot, inc, done_bg, done_car,
                                     done_erase, busy, xpoint, ypoint}), 0);
        in_sweep = 0;
        continue;
      end
      check("busy", int'(busy), int'(started && cyc >= busy_from && cyc < busy_until));
      if ({erase, draw_car, draw_bg} == 3'b000) begin
        if (in_sweep) begin
          check("sweep_cut_short", clen, (ckind == 0) ? BG_LEN : CAR_LEN);
          in_sweep = 0;
        end
        check("idle_quiet", int'({plot, inc, done_bg, done_car, done_erase}), 0);
      end else begin
        check("strobe_onehot", int'($onehot({erase, draw_car, draw_bg})), 1);
        kind = draw_bg ? 0 : (draw_car ? 1 : 2);
        if (!in_sweep || kind != ckind) begin
          if (in_sweep) check("sweep_cut_short", clen, (ckind == 0) ? BG_LEN : CAR_LEN);
          in_sweep = 1; ckind = kind; cx = int'(xpoint); cy = int'(ypoint);
          cfirst = cyc; clen = 0; cinc = 0;
        end else begin
          check("origin_stable", int'({xpoint, ypoint}), (cx << 8) | cy);
        end
        w = (kind == 0) ? SW : CW;
        h = (kind == 0) ? SH : CH;
        clen++;
        check("plot", int'(plot), 1);
        check("inc", int'(inc), int'((clen % w) == 0));
        if (inc) cinc++;
        check("done_pulse", int'({done_erase, done_car, done_bg}),
              (clen == w * h) ? (1 << kind) : 0);
        if (clen == w * h) begin
          if (exp_q.size() == 0) begin
            check("unexpected_sweep", kind, -1);
          end else begin
            e = exp_q.pop_front();
            check("sweep_kind", kind, e.kind);
            check("sweep_x", cx, e.x);
            check("sweep_y", cy, e.y);
            check("sweep_first_cycle", cfirst, e.first);
          end
          check("row_incs", cinc, h);
          in_sweep = 0;
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int n;
    reset = 1'b1; start = 1'b0; left = 1'b0; right = 1'b0;
    repeat (3) step(1, 0, 0, 0);
    repeat (20) step(0, 0, 0, 0);

    // Background fill, car draw, and a start pulse inside DRAW_CAR.
    step(0, 0, 0, 1);
    repeat (BG_LEN + 48) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    wait_model_idle();

    // One full move right, then a second move aborted by reset mid-erase.
    run_frame(0, 1);
    wait_model_idle();
    run_frame(0, 1);
    while (cyc < last_move + 40) step(0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0);

    // Restart: car redrawn at its reset origin.
    step(0, 0, 0, 1);
    wait_model_idle();

    // Drive to the right edge, then clamp, both-pressed, random, left edge.
    n = 0;
    while (mcx < X_MAX && n < 60) begin run_frame(0, 1); n++; end
    repeat (2) run_frame(0, 1);
    repeat (2) run_frame(1, 1);
    repeat (6) run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    n = 0;
    while (mcx > 0 && n < 90) begin run_frame(1, 0); n++; end
    run_frame(1, 0);

    n = 0;
    while (exp_q.size() != 0 && n < 400) begin step(0, 0, 0, 0); n++; end
    repeat (5) step(0, 0, 0, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
